switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
//
// PURPOSE
//   Conditions the raw slide-switch bus before it reaches the priority encoder.
//   Each bit is synchronised into clk with two flops, then debounced by its own
//   stability counter. Outputs are a clean level bus (sw_db, which feeds
//   priority_encoder.sw) and single-cycle per-bit rise/fall event pulses.
//   The encoder therefore never sees metastable or bouncing inputs.
//
// PARAMETERS
//   WIDTH          10       number of switch bits
//   STABLE_CYCLES  500000   consecutive clk cycles a synced bit must hold its new
//                           value before sw_db follows (10 ms at 50 MHz); must be >= 1
//
// PORTS
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   sw_raw     in   WIDTH  raw asynchronous switch inputs
//   sw_db      out  WIDTH  debounced switch levels
//   sw_rise    out  WIDTH  1-cycle pulse: sw_db bit went 0->1 this cycle
//   sw_fall    out  WIDTH  1-cycle pulse: sw_db bit went 1->0 this cycle
//   any_change out  1      1-cycle pulse, equal to |(sw_rise | sw_fall)
//
// BEHAVIOUR
//   - Clocking and reset:
//     - Single clock domain.
//     - Reset is asynchronous assert on rst_n low; all state is released synchronously.
//     - In reset, all outputs are 0, sync flops are 0, and counters are 0.
//   - Synchroniser:
//     - sync1 <= sw_raw; sync2 <= sync1 (per bit).
//     - No logic sits between the two stages.
//   - Counter:
//     - One counter per bit, width $clog2(STABLE_CYCLES+1).
//     - If sync2[i] == sw_db[i]: cnt[i] <= 0. Any glitch restarts the count.
//     - If they differ and cnt[i] < STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
//     - If they differ and cnt[i] == STABLE_CYCLES-1:
//       - sw_db[i] <= sync2[i] and cnt[i] <= 0.
//       - On the same edge, sw_rise[i] or sw_fall[i] <= 1, depending on direction.
//   - Pulses:
//     - sw_rise, sw_fall and any_change are registered.
//     - They are high for exactly one cycle and are 0 otherwise.
//     - They assert in the same cycle that sw_db changes.
//   - Latency: a clean step on sw_raw[i] appears on sw_db[i] exactly
//     2 + STABLE_CYCLES rising edges later. The pulse is on that same edge.
//   - Bits are fully independent:
//     - Several bits may update in the same cycle.
//     - Their pulses then assert together, and any_change is 1 for that one cycle.
//   - Counter never wraps: it saturates logically, because it clears on update.
//   - STABLE_CYCLES == 1:
//     - sw_db follows sync2 one cycle later.
//     - Pulses still behave exactly as above.
//   - Reset mid-count: the counter is discarded.
//     - After release, sw_db stays 0 until the full stability window passes on any bit held at 1.
//     - Bits held at 1 through reset produce a rise pulse after 2 + STABLE_CYCLES cycles.
//   - No combinational path from sw_raw to any output.
//
// TESTING (run with STABLE_CYCLES=4, WIDTH=10)
//   1. Hold rst_n=0 with sw_raw=10'h3FF.
//      -> all outputs 0.
//      Release reset.
//      -> sw_db=10'h3FF and sw_rise=10'h3FF on edge 6 after release, for 1 cycle.
//      -> any_change=1 for 1 cycle.
//   2. Clean step sw_raw[9] 0->1.
//      -> sw_db[9]=1 on edge 6.
//      -> sw_rise[9] pulses for 1 cycle; sw_fall stays 0.
//   3. Bounce: sw_raw[3] toggles 1,0,1,0 on successive cycles, then settles at 1.
//      -> sw_db[3] changes exactly once, 6 edges after the last toggle.
//      -> exactly one rise pulse.
//   4. Simultaneous edges: sw_raw 10'h001 -> 10'h200.
//      -> sw_fall[0] and sw_rise[9] pulse on the same cycle.
//      -> any_change high for exactly 1 cycle.
//   5. Glitch: a 3-cycle high pulse on sw_raw[5] (shorter than STABLE_CYCLES).
//      -> sw_db[5] stays 0; no pulses.
//   6. Assert rst_n=0 while a bit's counter is at 2.
//      -> outputs clear immediately, without waiting for clk.
//      -> after release, the full 2 + STABLE_CYCLES latency applies again.

Source files
------------

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-bit stability counter for the slide-switch bus.
// Produces clean levels (sw_db) and registered single-cycle rise/fall pulses.
module switch_debouncer #(
  parameter int WIDTH         = 10,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             any_change
);

  // Counter only ever needs to reach STABLE_CYCLES-1 before it clears.
  localparam int            CW       = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] rise_vec_d;
  logic [WIDTH-1:0] fall_vec_d;
  logic             any_change_q, any_change_d;

  // Synchroniser stages: pure wiring between flops, nothing in between.
  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_q, cnt_d;
      logic          db_q, db_d;
      logic          rise_q, rise_d;
      logic          fall_q, fall_d;

      // Count consecutive cycles the synced bit disagrees with the debounced level;
      // any agreement restarts the window, reaching the last count commits the change.
      always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync2_q[gi] == db_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          db_d   = sync2_q[gi];
          rise_d = sync2_q[gi];
          fall_d = ~sync2_q[gi];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Per-bit state: counter, level and event pulses.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q  <= '0;
          db_q   <= 1'b0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          db_q   <= db_d;
          rise_q <= rise_d;
          fall_q <= fall_d;
        end
      end

      assign sw_db[gi]      = db_q;
      assign sw_rise[gi]    = rise_q;
      assign sw_fall[gi]    = fall_q;
      assign rise_vec_d[gi] = rise_d;
      assign fall_vec_d[gi] = fall_d;
    end
  endgenerate

  // Summary pulse registered alongside the per-bit pulses so they line up.
  always_comb begin
    any_change_d = |(rise_vec_d | fall_vec_d);
  end

  // Summary pulse flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= any_change_d;
    end
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: window-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_switch_debouncer;

  localparam int W = 10;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_db, sw_rise, sw_fall;
  logic         any_change;

  int tests = 0;
  int errors = 0;

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_db     (sw_db),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  // Reference model: edges counted from reset release; raw sampled at edge k is
  // what the debouncer compares at edge k+2. A bit flips at edge n when the
  // compared value differed from the level on each of the last S edges, all of
  // them after the previous flip.
  logic [W-1:0] hist [0:4095];
  int           n_edge;
  int           last_flip [W];
  logic [W-1:0] m_db, m_rise, m_fall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edge <= 0;
      m_db   <= '0;
      m_rise <= '0;
      m_fall <= '0;
      for (int i = 0; i < W; i++) last_flip[i] <= 0;
    end else begin
      int           nn;
      logic [W-1:0] nd, nr, nf, h;
      logic         ok, s;
      nn = n_edge + 1;
      nd = m_db;
      nr = '0;
      nf = '0;
      for (int i = 0; i < W; i++) begin
        ok = (nn - last_flip[i]) >= S;
        for (int j = nn - S + 1; j <= nn; j++) begin
          if (j >= 3) begin
            h = hist[j-2];
            s = h[i];
          end else begin
            s = 1'b0;
          end
          if (s == m_db[i]) ok = 1'b0;
        end
        if (ok) begin
          nd[i] = ~m_db[i];
          nr[i] = ~m_db[i];
          nf[i] = m_db[i];
          last_flip[i] <= nn;
        end
      end
      hist[nn] <= sw_raw;
      n_edge   <= nn;
      m_db     <= nd;
      m_rise   <= nr;
      m_fall   <= nf;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model; also tallies pulses for scenario checks.
  int rise3_seen = 0;
  int any_seen = 0;
  always @(posedge clk) begin
    #1;
    chk("cyc_db",   32'(sw_db),      32'(m_db));
    chk("cyc_rise", 32'(sw_rise),    32'(m_rise));
    chk("cyc_fall", 32'(sw_fall),    32'(m_fall));
    chk("cyc_any",  32'(any_change), 32'(|(m_rise | m_fall)));
    if (sw_rise[3]) rise3_seen++;
    if (any_change) any_seen++;
  end

  task automatic wait_edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Literal expectation checked against both DUT and model.
  task automatic expect_all(input string name, input logic [W-1:0] db, input logic [W-1:0] r,
                            input logic [W-1:0] f, input logic a);
    chk({name, "_db"},   32'(sw_db),      32'(db));
    chk({name, "_rise"}, 32'(sw_rise),    32'(r));
    chk({name, "_fall"}, 32'(sw_fall),    32'(f));
    chk({name, "_any"},  32'(any_change), 32'(a));
    chk({name, "_mdl"},  32'(m_db),       32'(db));
  endtask

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    sw_raw = v;
  endtask

  initial begin
    // 1: reset with all switches high, then release.
    sw_raw = 10'h3FF;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    expect_all("t1_rst", 10'h000, 10'h000, 10'h000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(5);
    expect_all("t1_e5", 10'h000, 10'h000, 10'h000, 1'b0);
    wait_edges(1);
    expect_all("t1_e6", 10'h3FF, 10'h3FF, 10'h000, 1'b1);
    wait_edges(1);
    expect_all("t1_e7", 10'h3FF, 10'h000, 10'h000, 1'b0);
    $display("[TB] step 1 reset release with 3FF held");

    // 2: clear everything, then a clean step on bit 9.
    drive(10'h000);
    wait_edges(10);
    expect_all("t2_pre", 10'h000, 10'h000, 10'h000, 1'b0);
    drive(10'h200);
    wait_edges(5);
    expect_all("t2_e5", 10'h000, 10'h000, 10'h000, 1'b0);
    wait_edges(1);
    expect_all("t2_e6", 10'h200, 10'h200, 10'h000, 1'b1);
    wait_edges(1);
    expect_all("t2_e7", 10'h200, 10'h000, 10'h000, 1'b0);
    $display("[TB] step 2 clean rise on bit 9");

    // 3: bouncing bit 3 settling high.
    drive(10'h200);
    rise3_seen = 0;
    drive(10'h208);
    drive(10'h200);
    drive(10'h208);
    drive(10'h200);
    drive(10'h208);
    wait_edges(5);
    chk("t3_e5_db", 32'(sw_db), 32'h200);
    wait_edges(1);
    expect_all("t3_e6", 10'h208, 10'h008, 10'h000, 1'b1);
    wait_edges(6);
    chk("t3_one_rise", 32'(rise3_seen), 32'd1);
    $display("[TB] step 3 bounce on bit 3");

    // 4: simultaneous fall on bit 0 and rise on bit 9.
    drive(10'h001);
    wait_edges(10);
    expect_all("t4_pre", 10'h001, 10'h000, 10'h000, 1'b0);
    drive(10'h200);
    any_seen = 0;
    wait_edges(5);
    expect_all("t4_e5", 10'h001, 10'h000, 10'h000, 1'b0);
    wait_edges(1);
    expect_all("t4_e6", 10'h200, 10'h200, 10'h001, 1'b1);
    wait_edges(1);
    expect_all("t4_e7", 10'h200, 10'h000, 10'h000, 1'b0);
    chk("t4_any_once", 32'(any_seen), 32'd1);
    $display("[TB] step 4 simultaneous fall/rise");

    // 5: 3-cycle glitch on bit 5 must be rejected.
    any_seen = 0;
    drive(10'h220);
    drive(10'h220);
    drive(10'h220);
    drive(10'h200);
    wait_edges(12);
    expect_all("t5_after", 10'h200, 10'h000, 10'h000, 1'b0);
    chk("t5_no_pulse", 32'(any_seen), 32'd0);
    $display("[TB] step 5 glitch rejected");

    // 6: reset mid-count (bit 0 counter at 2), asynchronous clear, full latency after.
    drive(10'h201);
    wait_edges(4);
    chk("t6_pre_db", 32'(sw_db), 32'h200);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("t6_async", 10'h000, 10'h000, 10'h000, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_edges(5);
    expect_all("t6_e5", 10'h000, 10'h000, 10'h000, 1'b0);
    wait_edges(1);
    expect_all("t6_e6", 10'h201, 10'h201, 10'h000, 1'b1);
    wait_edges(1);
    expect_all("t6_e7", 10'h201, 10'h000, 10'h000, 1'b0);
    $display("[TB] step 6 reset mid-count");

    wait_edges(3);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
